// File: rtl/cpm_rc_pkg.sv
// -----------------------------------------------------------------------------
// cpm_rc_pkg
// Shared types for the CPM RC completion credit sink.
//   RC_DATA_W / RC_USER_W / RC_KEEP_W : RC beat field widths
//   rc_beat_t                         : one buffered RC beat (690 bits)
//   rc_sink_state_e                   : credit-sink FSM states
// -----------------------------------------------------------------------------
package cpm_rc_pkg;

    localparam int RC_DATA_W = 512;
    localparam int RC_USER_W = 161;
    localparam int RC_KEEP_W = 16;

    typedef struct packed {
        logic [RC_DATA_W-1:0] tdata;
        logic [RC_USER_W-1:0] tuser;
        logic [RC_KEEP_W-1:0] tkeep;
        logic                 tlast;
    } rc_beat_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rc_sink_state_e;

endpackage

// File: rtl/cpm_sync_fifo.sv
// -----------------------------------------------------------------------------
// cpm_sync_fifo
// First-word-fall-through synchronous FIFO of rc_beat_t. The head entry is
// always visible on rd_data while the FIFO is non-empty; a write into an
// empty FIFO is visible the cycle after it is clocked in.
//   clk, rst : clock, synchronous active-high reset (flushes all entries)
//   wr_en    : write request; accepted when not full, or full with a read
//   wr_data  : beat to write
//   rd_en    : read request; pops the head when not empty
//   rd_data  : head entry
//   level    : number of entries held
//   full     : level == DEPTH
//   empty    : level == 0
// -----------------------------------------------------------------------------
module cpm_sync_fifo
    import cpm_rc_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  rc_beat_t                     wr_data,
    input  logic                         rd_en,
    output rc_beat_t                     rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rc_beat_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (level == '0);
    assign full  = (level == CNT_W'(DEPTH));

    // A write at full is only taken when the same-cycle read frees the slot.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/cpm_rc_credit_sink.sv
// -----------------------------------------------------------------------------
// cpm_rc_credit_sink
// Receiving end of the CPM credit-based RC completion interface. RC beats
// arrive without backpressure and are buffered; each freed buffer entry is
// returned to the sender as a one-cycle credit pulse. Buffered beats leave on
// a valid/ready AXI-Stream master.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   INIT  | advertising the initial DEPTH credits, one per cycle
//   RUN   | steady state; credits returned as buffer entries are popped
//
// Ports:
//   user_clk, user_reset     : clock, synchronous active-high reset
//   s_axis_rc_*              : incoming RC beats (no ready)
//   s_axis_rc_credit         : one pulse = one credit granted
//   m_axis_rc_*              : buffered beats toward user logic
//   init_done                : initial credit advertisement complete
//   fifo_level               : entries currently buffered
//   credits_out              : credits held by the sender
//   overflow_err             : sticky; beat arrived with buffer full
// -----------------------------------------------------------------------------
module cpm_rc_credit_sink
    import cpm_rc_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 user_clk,
    input  logic                 user_reset,

    input  logic [RC_DATA_W-1:0] s_axis_rc_tdata,
    input  logic                 s_axis_rc_tlast,
    input  logic [RC_USER_W-1:0] s_axis_rc_tuser,
    input  logic [RC_KEEP_W-1:0] s_axis_rc_tkeep,
    input  logic                 s_axis_rc_tvalid,
    output logic                 s_axis_rc_credit,

    output logic [RC_DATA_W-1:0] m_axis_rc_tdata,
    output logic                 m_axis_rc_tlast,
    output logic [RC_USER_W-1:0] m_axis_rc_tuser,
    output logic [RC_KEEP_W-1:0] m_axis_rc_tkeep,
    output logic                 m_axis_rc_tvalid,
    input  logic                 m_axis_rc_tready,

    output logic                 init_done,
    output logic [CNT_W-1:0]     fifo_level,
    output logic [CNT_W-1:0]     credits_out,
    output logic                 overflow_err
);

    rc_sink_state_e   state;
    logic [CNT_W-1:0] pending;

    rc_beat_t         in_beat;
    rc_beat_t         head_beat;
    logic             fifo_full;
    logic             fifo_empty;

    logic             pop;
    logic             push_ok;
    logic             overflow;
    logic             issue;

    assign in_beat.tdata = s_axis_rc_tdata;
    assign in_beat.tuser = s_axis_rc_tuser;
    assign in_beat.tkeep = s_axis_rc_tkeep;
    assign in_beat.tlast = s_axis_rc_tlast;

    cpm_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (user_clk),
        .rst     (user_reset),
        .wr_en   (s_axis_rc_tvalid),
        .wr_data (in_beat),
        .rd_en   (m_axis_rc_tready),
        .rd_data (head_beat),
        .level   (fifo_level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_rc_tvalid = !fifo_empty;
    assign m_axis_rc_tdata  = head_beat.tdata;
    assign m_axis_rc_tuser  = head_beat.tuser;
    assign m_axis_rc_tkeep  = head_beat.tkeep;
    assign m_axis_rc_tlast  = head_beat.tlast;

    assign pop      = m_axis_rc_tvalid && m_axis_rc_tready;
    assign push_ok  = s_axis_rc_tvalid && (!fifo_full || pop);
    assign overflow = s_axis_rc_tvalid && fifo_full && !pop;

    // A pop turns straight into a credit when nothing is pending, so the
    // pulse appears the cycle after the pop rather than two cycles later.
    assign issue = (pending != '0) || pop;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            state            <= INIT;
            pending          <= CNT_W'(DEPTH);
            credits_out      <= '0;
            s_axis_rc_credit <= 1'b0;
            init_done        <= 1'b0;
            overflow_err     <= 1'b0;
        end else begin
            s_axis_rc_credit <= issue;

            // issue always covers a same-cycle pop, so pending only moves down
            if (issue && !pop) begin
                pending <= pending - CNT_W'(1);
            end

            // A push with no credit held (only reachable at full with a pop)
            // is netted against the credit issued in the same cycle.
            case ({issue, push_ok})
                2'b10: credits_out <= credits_out + CNT_W'(1);
                2'b01: begin
                    if (credits_out != '0) begin
                        credits_out <= credits_out - CNT_W'(1);
                    end
                end
                default: credits_out <= credits_out;
            endcase

            if (overflow) begin
                overflow_err <= 1'b1;
            end

            case (state)
                INIT: begin
                    if (pending == '0) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    // Every credit is either buffered, held by the sender, or waiting to go.
    always @(posedge user_clk) begin
        if (!user_reset) begin
            assert ((CNT_W+2)'(fifo_level) + (CNT_W+2)'(credits_out) +
                    (CNT_W+2)'(pending) == (CNT_W+2)'(DEPTH));
        end
    end

endmodule

// File: tb/tb_cpm_rc_credit_sink.sv
// -----------------------------------------------------------------------------
// tb_cpm_rc_credit_sink
// Directed bench for cpm_rc_credit_sink with DEPTH = 8.
// -----------------------------------------------------------------------------
module tb_cpm_rc_credit_sink;
    import cpm_rc_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 user_clk;
    logic                 user_reset;
    logic [RC_DATA_W-1:0] s_axis_rc_tdata;
    logic                 s_axis_rc_tlast;
    logic [RC_USER_W-1:0] s_axis_rc_tuser;
    logic [RC_KEEP_W-1:0] s_axis_rc_tkeep;
    logic                 s_axis_rc_tvalid;
    logic                 s_axis_rc_credit;
    logic [RC_DATA_W-1:0] m_axis_rc_tdata;
    logic                 m_axis_rc_tlast;
    logic [RC_USER_W-1:0] m_axis_rc_tuser;
    logic [RC_KEEP_W-1:0] m_axis_rc_tkeep;
    logic                 m_axis_rc_tvalid;
    logic                 m_axis_rc_tready;
    logic                 init_done;
    logic [CNT_W-1:0]     fifo_level;
    logic [CNT_W-1:0]     credits_out;
    logic                 overflow_err;

    int n_tests = 0;
    int n_fail  = 0;

    cpm_rc_credit_sink #(
        .DEPTH (DEPTH)
    ) dut (
        .user_clk         (user_clk),
        .user_reset       (user_reset),
        .s_axis_rc_tdata  (s_axis_rc_tdata),
        .s_axis_rc_tlast  (s_axis_rc_tlast),
        .s_axis_rc_tuser  (s_axis_rc_tuser),
        .s_axis_rc_tkeep  (s_axis_rc_tkeep),
        .s_axis_rc_tvalid (s_axis_rc_tvalid),
        .s_axis_rc_credit (s_axis_rc_credit),
        .m_axis_rc_tdata  (m_axis_rc_tdata),
        .m_axis_rc_tlast  (m_axis_rc_tlast),
        .m_axis_rc_tuser  (m_axis_rc_tuser),
        .m_axis_rc_tkeep  (m_axis_rc_tkeep),
        .m_axis_rc_tvalid (m_axis_rc_tvalid),
        .m_axis_rc_tready (m_axis_rc_tready),
        .init_done        (init_done),
        .fifo_level       (fifo_level),
        .credits_out      (credits_out),
        .overflow_err     (overflow_err)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    function automatic rc_beat_t mk(input int i);
        rc_beat_t b;
        b.tdata = {16{32'hC0DE_0000 + 32'(i)}};
        b.tuser = 161'(i * 7 + 3);
        b.tkeep = 16'(16'hFFFF >> (i % 4));
        b.tlast = ((i % 2) == 1);
        return b;
    endfunction

    function automatic rc_beat_t head();
        rc_beat_t b;
        b.tdata = m_axis_rc_tdata;
        b.tuser = m_axis_rc_tuser;
        b.tkeep = m_axis_rc_tkeep;
        b.tlast = m_axis_rc_tlast;
        return b;
    endfunction

    task automatic drive(input rc_beat_t b, input logic v);
        s_axis_rc_tdata  = b.tdata;
        s_axis_rc_tuser  = b.tuser;
        s_axis_rc_tkeep  = b.tkeep;
        s_axis_rc_tlast  = b.tlast;
        s_axis_rc_tvalid = v;
    endtask

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [695:0] obs, input logic [695:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    rc_beat_t dead;
    int       pulses;

    initial begin
        user_reset       = 1'b1;
        m_axis_rc_tready = 1'b1;
        drive('0, 1'b0);
        step();
        step();

        // reset state
        chk("rst_credit",      s_axis_rc_credit, 0);
        chk("rst_tvalid",      m_axis_rc_tvalid, 0);
        chk("rst_init_done",   init_done,        0);
        chk("rst_level",       fifo_level,       0);
        chk("rst_credits_out", credits_out,      0);
        chk("rst_overflow",    overflow_err,     0);
        chk("rst_payload",     head(),           0);

        // initial credit advertisement: pulses on cycles 1..8
        user_reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("init_credit",      s_axis_rc_credit, (k <= 8));
            chk("init_credits_out", credits_out,      (k < 8) ? k : 8);
            chk("init_done",        init_done,        (k >= 9));
        end

        // fill the buffer with tready low
        m_axis_rc_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(mk(i), 1'b1);
            step();
            chk("fill_credit", s_axis_rc_credit, 0);
            chk("fill_level",  fifo_level,       i + 1);
            chk("fill_tvalid", m_axis_rc_tvalid, 1);
            chk("fill_head",   head(),           mk(0));
        end
        drive('0, 1'b0);
        step();
        step();
        chk("full_level",       fifo_level,       8);
        chk("full_credits_out", credits_out,      0);
        chk("full_credit",      s_axis_rc_credit, 0);
        chk("full_head_stable", head(),           mk(0));

        // three pops, each returning a credit the following cycle
        m_axis_rc_tready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            chk("pop_head", head(), mk(j));
            step();
            chk("pop_credit", s_axis_rc_credit, 1);
        end
        m_axis_rc_tready = 1'b0;
        step();
        chk("pop3_credit",      s_axis_rc_credit, 0);
        chk("pop3_level",       fifo_level,       5);
        chk("pop3_credits_out", credits_out,      3);
        chk("pop3_head",        head(),           mk(3));

        // refill to full
        for (int i = 8; i < 11; i++) begin
            drive(mk(i), 1'b1);
            step();
        end
        drive('0, 1'b0);
        chk("refill_level",       fifo_level,  8);
        chk("refill_credits_out", credits_out, 0);

        // push and pop together at full
        drive(mk(11), 1'b1);
        m_axis_rc_tready = 1'b1;
        chk("pp_head_before", head(), mk(3));
        step();
        drive('0, 1'b0);
        m_axis_rc_tready = 1'b0;
        chk("pp_overflow",    overflow_err,     0);
        chk("pp_level",       fifo_level,       8);
        chk("pp_credit",      s_axis_rc_credit, 1);
        chk("pp_credits_out", credits_out,      0);
        chk("pp_head_after",  head(),           mk(4));
        step();
        chk("pp_credit_once", s_axis_rc_credit, 0);

        // ninth beat at full without a pop is dropped
        dead       = mk(0);
        dead.tdata = 512'hDEAD;
        drive(dead, 1'b1);
        step();
        drive('0, 1'b0);
        chk("ovf_flag",        overflow_err,     1);
        chk("ovf_level",       fifo_level,       8);
        chk("ovf_credits_out", credits_out,      0);
        chk("ovf_credit",      s_axis_rc_credit, 0);
        chk("ovf_head",        head(),           mk(4));
        step();
        step();
        chk("ovf_sticky", overflow_err, 1);

        // drain: beats 4..11 in order, the dropped beat never shows
        m_axis_rc_tready = 1'b1;
        for (int j = 4; j < 12; j++) begin
            chk("drain_head", head(), mk(j));
            step();
            chk("drain_credit", s_axis_rc_credit, 1);
        end
        m_axis_rc_tready = 1'b0;
        chk("drain_level",       fifo_level,       0);
        chk("drain_tvalid",      m_axis_rc_tvalid, 0);
        chk("drain_credits_out", credits_out,      8);
        chk("drain_ovf_sticky",  overflow_err,     1);

        // reset with five beats buffered
        for (int i = 12; i < 17; i++) begin
            drive(mk(i), 1'b1);
            step();
        end
        drive('0, 1'b0);
        chk("pre_rst_level",       fifo_level,  5);
        chk("pre_rst_credits_out", credits_out, 3);
        user_reset = 1'b1;
        step();
        chk("mid_rst_tvalid",      m_axis_rc_tvalid, 0);
        chk("mid_rst_level",       fifo_level,       0);
        chk("mid_rst_credits_out", credits_out,      0);
        chk("mid_rst_overflow",    overflow_err,     0);
        chk("mid_rst_init_done",   init_done,        0);
        chk("mid_rst_payload",     head(),           0);
        user_reset = 1'b0;
        pulses     = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (s_axis_rc_credit) pulses++;
        end
        chk("reinit_pulses",      pulses,      8);
        chk("reinit_credits_out", credits_out, 8);
        chk("reinit_done",        init_done,   1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
